// File: rtl/uart_transmitter_if.sv
// Byte write port between the system side and the UART transmitter.
// The system side drives the write; the transmitter reports busy/done.
interface uart_transmitter_if #(
  parameter int DATA_W = 8
);
  logic              Tx_EN;
  logic              Tx_WR;
  logic [DATA_W-1:0] Tx_DATA;
  logic              Tx_BUSY;
  logic              Tx_DONE;

  modport master (
    output Tx_EN,
    output Tx_WR,
    output Tx_DATA,
    input  Tx_BUSY,
    input  Tx_DONE
  );

  modport slave (
    input  Tx_EN,
    input  Tx_WR,
    input  Tx_DATA,
    output Tx_BUSY,
    output Tx_DONE
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit stage: serialises one byte per frame on TxD,
// timed by the baud sampler tick (start, data LSB first, parity, stop).
module uart_transmitter #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_ENABLE,
  uart_transmitter_if.slave   tx,
  output logic                TxD
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TMAX = TW'(OVERSAMPLE - 1);
  localparam logic [2:0] BLAST = 3'(DATA_W - 1);
  localparam logic [2:0] SLAST = 3'(STOP_BITS - 1);
  localparam logic PODD = (PARITY_ODD != 0);
  localparam bit   PEN  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e            state_q;
  logic [TW-1:0]     tick_q;
  logic [2:0]        bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic              txd_q;
  logic              busy_q;
  logic              done_q;

  logic accept;
  logic bit_end;

  assign accept  = tx.Tx_EN & tx.Tx_WR & ~busy_q;
  assign bit_end = sample_ENABLE & (tick_q == TMAX);

  assign TxD        = txd_q;
  assign tx.Tx_BUSY = busy_q;
  assign tx.Tx_DONE = done_q;

  // Frame sequencer: bit timing, shifting and registered line/flag outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE:   txd_q <= 1'b1;
        START:  txd_q <= 1'b0;
        DATA:   txd_q <= shift_q[0];
        PARITY: txd_q <= par_q;
        STOP:   txd_q <= 1'b1;
        default: txd_q <= 1'b1;
      endcase
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= tx.Tx_DATA;
            par_q   <= (^tx.Tx_DATA) ^ PODD;
            tick_q  <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START, DATA, PARITY, STOP: begin
          if (sample_ENABLE) begin
            tick_q <= bit_end ? '0 : tick_q + 1'b1;
          end
          if (bit_end) begin
            case (state_q)
              START: begin
                bit_q   <= '0;
                state_q <= DATA;
              end
              DATA: begin
                shift_q <= shift_q >> 1;
                if (bit_q == BLAST) begin
                  bit_q   <= '0;
                  state_q <= PEN ? PARITY : STOP;
                end else begin
                  bit_q <= bit_q + 1'b1;
                end
              end
              PARITY: begin
                bit_q   <= '0;
                state_q <= STOP;
              end
              default: begin
                if (bit_q == SLAST) begin
                  bit_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
                end else begin
                  bit_q <= bit_q + 1'b1;
                end
              end
            endcase
          end
        end
        default: begin
          state_q <= IDLE;
          tick_q  <= '0;
          bit_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: three parameter sets share
// one clock and one baud tick (every 4 clks, 16 ticks per bit).
module tb_uart_transmitter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic se = 1'b0;
  logic txd0, txd1, txd2;

  always #5 clk = ~clk;

  uart_transmitter_if #(.DATA_W(8)) if0 ();
  uart_transmitter_if #(.DATA_W(8)) if1 ();
  uart_transmitter_if #(.DATA_W(8)) if2 ();

  uart_transmitter #(.PARITY_ODD(0)) u0 (
    .clk(clk), .reset(reset), .sample_ENABLE(se),
    .tx(if0), .TxD(txd0)
  );
  uart_transmitter #(.PARITY_ODD(1)) u1 (
    .clk(clk), .reset(reset), .sample_ENABLE(se),
    .tx(if1), .TxD(txd1)
  );
  uart_transmitter #(.PARITY_EN(0)) u2 (
    .clk(clk), .reset(reset), .sample_ENABLE(se),
    .tx(if2), .TxD(txd2)
  );

  int errors = 0;
  int checks = 0;
  int div = 0;
  int done_c [3] = '{0, 0, 0};
  int low_c  [3] = '{0, 0, 0};
  int busy_c [3] = '{0, 0, 0};

  // Baud tick: one clk wide, every 4th cycle, changed on falling edges.
  initial begin
    forever begin
      @(negedge clk);
      div = div + 1;
      se = (div % 4 == 0);
    end
  end

  // Per-DUT event counters sampled on the active edge.
  always @(posedge clk) begin
    done_c[0] <= done_c[0] + int'(if0.Tx_DONE);
    done_c[1] <= done_c[1] + int'(if1.Tx_DONE);
    done_c[2] <= done_c[2] + int'(if2.Tx_DONE);
    low_c[0]  <= low_c[0] + int'(!txd0);
    low_c[1]  <= low_c[1] + int'(!txd1);
    low_c[2]  <= low_c[2] + int'(!txd2);
    busy_c[0] <= busy_c[0] + int'(if0.Tx_BUSY);
    busy_c[1] <= busy_c[1] + int'(if1.Tx_BUSY);
    busy_c[2] <= busy_c[2] + int'(if2.Tx_BUSY);
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic txd_of(input int w);
    case (w)
      0: return txd0;
      1: return txd1;
      default: return txd2;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0: return if0.Tx_BUSY;
      1: return if1.Tx_BUSY;
      default: return if2.Tx_BUSY;
    endcase
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      0: return if0.Tx_DONE;
      1: return if1.Tx_DONE;
      default: return if2.Tx_DONE;
    endcase
  endfunction

  task automatic wr_set(input int w, input logic en,
                        input logic wr, input logic [7:0] d);
    case (w)
      0: begin if0.Tx_EN = en; if0.Tx_WR = wr; if0.Tx_DATA = d; end
      1: begin if1.Tx_EN = en; if1.Tx_WR = wr; if1.Tx_DATA = d; end
      default: begin if2.Tx_EN = en; if2.Tx_WR = wr; if2.Tx_DATA = d; end
    endcase
  endtask

  task automatic write(input int w, input logic [7:0] d);
    @(negedge clk);
    wr_set(w, 1'b1, 1'b1, d);
    @(negedge clk);
    wr_set(w, 1'b1, 1'b0, d);
  endtask

  // Waits for a start bit, then samples each bit near its centre.
  task automatic capture(input int w, input int n,
                         output logic [10:0] bits, output bit ok);
    bits = '1;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk);
      #1;
      if (txd_of(w) === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (32) @(posedge clk);
      #1;
      bits[0] = txd_of(w);
      for (int k = 1; k < n; k++) begin
        repeat (64) @(posedge clk);
        #1;
        bits[k] = txd_of(w);
      end
    end
  endtask

  task automatic test_reset;
    int d, l, b;
    wr_set(0, 1'b0, 1'b0, 8'h00);
    wr_set(1, 1'b0, 1'b0, 8'h00);
    wr_set(2, 1'b0, 1'b0, 8'h00);
    #12;
    for (int w = 0; w < 3; w++) begin
      checks++;
      if ({txd_of(w), busy_of(w), done_of(w)} !== 3'b100) begin
        errors++;
        $display("FAIL reset_init[%0d]: got txd/busy/done=%b want 100", w,
                 {txd_of(w), busy_of(w), done_of(w)});
      end
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    write(0, 8'h5A);
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if ({txd0, if0.Tx_BUSY} !== 2'b01) begin
      errors++;
      $display("FAIL reset_midframe_pre: got txd/busy=%b want 01",
               {txd0, if0.Tx_BUSY});
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({txd0, if0.Tx_BUSY, if0.Tx_DONE} !== 3'b100) begin
      errors++;
      $display("FAIL reset_async: got txd/busy/done=%b want 100",
               {txd0, if0.Tx_BUSY, if0.Tx_DONE});
    end
    d = done_c[0];
    l = low_c[0];
    b = busy_c[0];
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (done_c[0] !== d || low_c[0] !== l || busy_c[0] !== b) begin
      errors++;
      $display("FAIL reset_after: got done/low/busy deltas %0d/%0d/%0d want 0/0/0",
               done_c[0] - d, low_c[0] - l, busy_c[0] - b);
    end
  endtask

  task automatic test_default_frame;
    logic [10:0] bits;
    logic [10:0] exp;
    bit ok;
    bit pok;
    int per;
    int d, b;
    exp = {1'b1, 1'b0, 8'hA5, 1'b0};
    d = done_c[0];
    b = busy_c[0];
    per = 0;
    pok = 1'b0;
    fork
      capture(0, 11, bits, ok);
      write(0, 8'hA5);
      begin
        int st;
        st = 0;
        for (int t = 0; t < 3000 && st < 3; t++) begin
          @(posedge clk);
          #1;
          if (st == 0 && txd0 === 1'b0) st = 1;
          else if (st == 1 && txd0 === 1'b1) st = 2;
          else if (st == 2) begin
            per++;
            if (txd0 === 1'b0) begin
              st = 3;
              pok = 1'b1;
            end
          end
        end
      end
    join
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (!ok || bits !== exp) begin
      errors++;
      $display("FAIL frame_A5: got %b (start_seen=%0d) want %b", bits, ok, exp);
    end
    checks++;
    if (!pok || per != 64) begin
      errors++;
      $display("FAIL bit_period: got %0d clks want 64", per);
    end
    checks++;
    if (done_c[0] - d != 1) begin
      errors++;
      $display("FAIL done_A5: got %0d pulses want 1", done_c[0] - d);
    end
    checks++;
    if (busy_c[0] - b < 701 || busy_c[0] - b > 704) begin
      errors++;
      $display("FAIL busy_len_A5: got %0d clks want 701..704", busy_c[0] - b);
    end
  endtask

  task automatic test_parity_modes;
    logic [10:0] bits;
    bit ok;
    int d, b;
    fork
      capture(1, 11, bits, ok);
      write(1, 8'h07);
    join
    checks++;
    if (!ok || bits !== {1'b1, 1'b0, 8'h07, 1'b0}) begin
      errors++;
      $display("FAIL odd_parity_07: got %b want %b", bits,
               {1'b1, 1'b0, 8'h07, 1'b0});
    end
    repeat (100) @(posedge clk);
    d = done_c[2];
    b = busy_c[2];
    fork
      capture(2, 10, bits, ok);
      write(2, 8'hFF);
    join
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (!ok || bits !== {2'b11, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL no_parity_FF: got %b want %b", bits, {2'b11, 8'hFF, 1'b0});
    end
    checks++;
    if (busy_c[2] - b < 637 || busy_c[2] - b > 640) begin
      errors++;
      $display("FAIL busy_len_noparity: got %0d clks want 637..640",
               busy_c[2] - b);
    end
    checks++;
    if (done_c[2] - d != 1) begin
      errors++;
      $display("FAIL done_noparity: got %0d pulses want 1", done_c[2] - d);
    end
  endtask

  task automatic test_write_while_busy;
    logic [10:0] bits;
    bit ok;
    int d;
    d = done_c[0];
    fork
      capture(0, 11, bits, ok);
      begin
        @(negedge clk);
        wr_set(0, 1'b1, 1'b1, 8'h3C);
        @(negedge clk);
        wr_set(0, 1'b1, 1'b1, 8'hC3);
        repeat (100) @(negedge clk);
        wr_set(0, 1'b1, 1'b1, 8'h00);
        repeat (200) @(negedge clk);
        wr_set(0, 1'b1, 1'b1, 8'hFF);
        repeat (100) @(negedge clk);
        wr_set(0, 1'b1, 1'b0, 8'h99);
      end
    join
    repeat (900) @(posedge clk);
    #1;
    checks++;
    if (!ok || bits !== {1'b1, 1'b0, 8'h3C, 1'b0}) begin
      errors++;
      $display("FAIL busy_write_3C: got %b want %b", bits,
               {1'b1, 1'b0, 8'h3C, 1'b0});
    end
    checks++;
    if (done_c[0] - d != 1 || if0.Tx_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL busy_write_single: got %0d frames busy=%b want 1 frames busy=0",
               done_c[0] - d, if0.Tx_BUSY);
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] b1, b2;
    bit ok1, ok2;
    bit seen;
    int d;
    d = done_c[0];
    seen = 1'b0;
    fork
      begin
        capture(0, 11, b1, ok1);
        capture(0, 11, b2, ok2);
      end
      begin
        write(0, 8'h55);
        for (int t = 0; t < 2000; t++) begin
          @(negedge clk);
          if (if0.Tx_BUSY === 1'b0) begin
            seen = 1'b1;
            break;
          end
        end
        wr_set(0, 1'b1, 1'b1, 8'hAA);
        @(negedge clk);
        checks++;
        if (!seen || if0.Tx_BUSY !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gap: got busy=%b (fall_seen=%0d) want 1", if0.Tx_BUSY,
                   seen);
        end
        wr_set(0, 1'b1, 1'b0, 8'h00);
      end
    join
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (!ok1 || b1 !== {1'b1, 1'b0, 8'h55, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first: got %b want %b", b1, {1'b1, 1'b0, 8'h55, 1'b0});
    end
    checks++;
    if (!ok2 || b2 !== {1'b1, 1'b0, 8'hAA, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second: got %b want %b", b2, {1'b1, 1'b0, 8'hAA, 1'b0});
    end
    checks++;
    if (done_c[0] - d != 2) begin
      errors++;
      $display("FAIL b2b_done: got %0d pulses want 2", done_c[0] - d);
    end
  endtask

  task automatic test_enable;
    logic [10:0] bits;
    bit ok;
    int d, l, b;
    l = low_c[0];
    b = busy_c[0];
    @(negedge clk);
    wr_set(0, 1'b0, 1'b1, 8'h12);
    repeat (50) @(negedge clk);
    checks++;
    if (low_c[0] !== l || busy_c[0] !== b || if0.Tx_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL en_blocked: got low/busy deltas %0d/%0d want 0/0",
               low_c[0] - l, busy_c[0] - b);
    end
    wr_set(0, 1'b0, 1'b0, 8'h12);
    d = done_c[0];
    fork
      capture(0, 11, bits, ok);
      begin
        write(0, 8'h81);
        repeat (300) @(negedge clk);
        wr_set(0, 1'b0, 1'b0, 8'h81);
      end
    join
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (!ok || bits !== {1'b1, 1'b0, 8'h81, 1'b0}) begin
      errors++;
      $display("FAIL en_drop_81: got %b want %b", bits, {1'b1, 1'b0, 8'h81, 1'b0});
    end
    checks++;
    if (done_c[0] - d != 1) begin
      errors++;
      $display("FAIL en_drop_done: got %0d pulses want 1", done_c[0] - d);
    end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_parity_modes();
    test_write_while_busy();
    test_back_to_back();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
